// File: rtl/montador_linha_if.sv
// montador_linha_if: beat input bus and line output handshake of the line
// assembler. The slave modport is the assembler's view; master is the view of
// whatever drives beats and consumes lines.
interface montador_linha_if #(
    parameter int TAM_BEAT     = 64,
    parameter int TAM_LINHA    = 512,
    parameter int TAM_ENDERECO = 64
) ();
    logic                    beat_valido;
    logic [TAM_BEAT-1:0]     beat_dado;
    logic [TAM_ENDERECO-1:0] beat_endereco;
    logic                    beat_ultimo;
    logic                    beat_pronto;
    logic [TAM_LINHA-1:0]    linha_cache;
    logic [TAM_ENDERECO-1:0] endereco;
    logic                    linha_valida;
    logic                    linha_pronta;

    modport slave (
        input  beat_valido, beat_dado, beat_endereco, beat_ultimo, linha_pronta,
        output beat_pronto, linha_cache, endereco, linha_valida
    );

    modport master (
        output beat_valido, beat_dado, beat_endereco, beat_ultimo, linha_pronta,
        input  beat_pronto, linha_cache, endereco, linha_valida
    );
endinterface

// File: rtl/montador_linha.sv
// montador_linha: assembles 8-beat bursts of 64-bit beats into 512-bit cache
// lines tagged with their line-aligned address and queues them in a small FIFO.
// Malformed bursts are dropped with a one-cycle erro_protocolo pulse.
// Optional feature: define MONTADOR_FILTRO_ZERO_EN to drop all-zero lines and
// count them in contador_zeros (tied to 0 otherwise).
module montador_linha #(
    parameter int TAM_BEAT     = 64,
    parameter int TAM_LINHA    = 512,
    parameter int TAM_ENDERECO = 64,
    parameter int PROF_FILA    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    montador_linha_if.slave            bus,
    output logic [$clog2(PROF_FILA):0] nivel_fila,
    output logic                       erro_protocolo,
    output logic [15:0]                contador_zeros
);
    localparam int BEATS = TAM_LINHA / TAM_BEAT;
    localparam int IW    = $clog2(BEATS);
    localparam int AW    = $clog2(PROF_FILA);
    localparam int OFS   = $clog2(TAM_LINHA / 8);
    localparam logic [IW-1:0] IND_ULTIMO = IW'(BEATS - 1);
    localparam logic [TAM_ENDERECO-1:0] MASCARA = ~TAM_ENDERECO'((64'd1 << OFS) - 64'd1);

    typedef enum logic [0:0] {
        OCIOSO   = 1'b0,
        MONTANDO = 1'b1
    } estado_t;

    estado_t                 estado_r, estado_s;
    logic [IW-1:0]           indice_r, indice_s;
    logic [TAM_LINHA-1:0]    linha_r;
    logic [TAM_LINHA-1:0]    linha_nova_s;
    logic [TAM_ENDERECO-1:0] end_r;
    logic                    aceito_s, push_s, erro_s, pop_s, cheia_s;
    logic [AW:0]             wr_ptr_r, rd_ptr_r, nivel_s;
    logic [TAM_LINHA-1:0]    mem_linha [PROF_FILA];
    logic [TAM_ENDERECO-1:0] mem_end   [PROF_FILA];
`ifdef MONTADOR_FILTRO_ZERO_EN
    logic                    zero_s;
    logic [15:0]             contador_zeros_r;
`endif

    // Occupancy is the pointer difference; the extra pointer bit separates full from empty.
    assign nivel_s      = wr_ptr_r - rd_ptr_r;
    assign cheia_s      = (nivel_s == (AW + 1)'(PROF_FILA));
    assign nivel_fila   = nivel_s;

    // Only the line-completing beat has to wait for FIFO space.
    assign bus.beat_pronto  = ~((indice_r == IND_ULTIMO) & cheia_s);
    assign aceito_s         = bus.beat_valido & bus.beat_pronto;
    assign bus.linha_valida = (nivel_s != '0);
    assign pop_s            = bus.linha_valida & bus.linha_pronta;

    // The final beat goes straight into the FIFO entry together with the seven held beats.
    assign linha_nova_s = {bus.beat_dado, linha_r[TAM_LINHA-TAM_BEAT-1:0]};

    // Head outputs read as zero while empty, so they are zero immediately on reset.
    assign bus.linha_cache = bus.linha_valida ? mem_linha[rd_ptr_r[AW-1:0]] : '0;
    assign bus.endereco    = bus.linha_valida ? mem_end[rd_ptr_r[AW-1:0]]   : '0;

`ifdef MONTADOR_FILTRO_ZERO_EN
    function automatic logic linha_zero(input logic [TAM_LINHA-1:0] l);
        return (l == '0);
    endfunction
`endif

    // Burst FSM: next state, beat index, push and protocol-error decisions.
    always_comb begin
        estado_s = estado_r;
        indice_s = indice_r;
        push_s   = 1'b0;
        erro_s   = 1'b0;
`ifdef MONTADOR_FILTRO_ZERO_EN
        zero_s   = 1'b0;
`endif
        if (aceito_s) begin
            case (estado_r)
                OCIOSO: begin
                    if (bus.beat_ultimo) begin
                        erro_s   = 1'b1;
                        estado_s = OCIOSO;
                        indice_s = '0;
                    end else begin
                        estado_s = MONTANDO;
                        indice_s = IW'(1);
                    end
                end
                MONTANDO: begin
                    if (indice_r == IND_ULTIMO) begin
                        estado_s = OCIOSO;
                        indice_s = '0;
                        if (bus.beat_ultimo) begin
`ifdef MONTADOR_FILTRO_ZERO_EN
                            if (linha_zero(linha_nova_s)) begin
                                zero_s = 1'b1;
                            end else begin
                                push_s = 1'b1;
                            end
`else
                            push_s = 1'b1;
`endif
                        end else begin
                            erro_s = 1'b1;
                        end
                    end else if (bus.beat_ultimo) begin
                        erro_s   = 1'b1;
                        estado_s = OCIOSO;
                        indice_s = '0;
                    end else begin
                        indice_s = indice_r + IW'(1);
                    end
                end
                default: begin
                    estado_s = OCIOSO;
                    indice_s = '0;
                end
            endcase
        end else begin
            estado_s = estado_r;
        end
    end

    // FSM state, partial line, latched address and the registered error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_r       <= OCIOSO;
            indice_r       <= '0;
            linha_r        <= '0;
            end_r          <= '0;
            erro_protocolo <= 1'b0;
        end else begin
            estado_r       <= estado_s;
            indice_r       <= indice_s;
            erro_protocolo <= erro_s;
            if (aceito_s) begin
                linha_r[int'(indice_r) * TAM_BEAT +: TAM_BEAT] <= bus.beat_dado;
                if (estado_r == OCIOSO) begin
                    end_r <= bus.beat_endereco & MASCARA;
                end
            end
        end
    end

    // FIFO pointers; push and pop may happen in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
            end
        end
    end

    // FIFO storage for completed lines and their addresses.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_linha[wr_ptr_r[AW-1:0]] <= linha_nova_s;
            mem_end[wr_ptr_r[AW-1:0]]   <= end_r;
        end
    end

`ifdef MONTADOR_FILTRO_ZERO_EN
    // Saturating count of all-zero lines that were dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contador_zeros_r <= 16'h0000;
        end else if (zero_s && (contador_zeros_r != 16'hFFFF)) begin
            contador_zeros_r <= contador_zeros_r + 16'h0001;
        end
    end

    assign contador_zeros = contador_zeros_r;
`else
    assign contador_zeros = 16'h0000;
`endif

endmodule

// File: tb/tb_montador_linha.sv
// tb_montador_linha: directed testbench for montador_linha. Inputs change on the
// falling edge, outputs are checked on the falling edge.
module tb_montador_linha;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  nivel_fila;
    logic        erro;
    logic [15:0] cz;
    int          n_aval = 0;
    int          n_falhas = 0;
    int          q_ids[$];

    montador_linha_if bus ();

    montador_linha dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .nivel_fila     (nivel_fila),
        .erro_protocolo (erro),
        .contador_zeros (cz)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [511:0] obs, input logic [511:0] esp);
        n_aval++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: observed %h expected %h", tag, obs, esp);
        end
    endtask

    function automatic logic [63:0] dado(input int id, input int k);
        return {32'hA5A5_0000 + 32'(id), 32'h0101_0000 + 32'(k)};
    endfunction

    function automatic logic [63:0] end_de(input int id);
        return 64'h0000_1000_0000_0000 + 64'(id) * 64'h1C7;
    endfunction

    function automatic logic [511:0] linha_esp(input int id);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = dado(id, k);
        return l;
    endfunction

    // Starts and ends on a falling edge; returns just after the accepting edge.
    task automatic envia_beat(input logic [63:0] d, input logic [63:0] a, input logic u);
        int espera = 0;
        bus.beat_valido   = 1'b1;
        bus.beat_dado     = d;
        bus.beat_endereco = a;
        bus.beat_ultimo   = u;
        while (!bus.beat_pronto && espera < 50) begin
            @(negedge clk);
            espera++;
        end
        if (espera >= 50) verifica("beat_pronto_timeout", 512'd0, 512'd1);
        @(negedge clk);
        bus.beat_valido = 1'b0;
        bus.beat_ultimo = 1'b0;
    endtask

    task automatic envia_rajada(input int id, input int n, input int idx_ultimo);
        for (int k = 0; k < n; k++) envia_beat(dado(id, k), end_de(id), k == idx_ultimo);
    endtask

    task automatic retira(input int id);
        verifica("pop_valida", bus.linha_valida, 1'b1);
        verifica("pop_linha", bus.linha_cache, linha_esp(id));
        verifica("pop_end", bus.endereco, end_de(id) & 64'hFFFF_FFFF_FFFF_FFC0);
        bus.linha_pronta = 1'b1;
        @(negedge clk);
        bus.linha_pronta = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] nib;
        bus.beat_valido = 1'b0; bus.beat_dado = '0; bus.beat_endereco = '0;
        bus.beat_ultimo = 1'b0; bus.linha_pronta = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state
        verifica("rst_pronto", bus.beat_pronto, 1'b1);
        verifica("rst_valida", bus.linha_valida, 1'b0);
        verifica("rst_nivel", nivel_fila, 3'd0);
        verifica("rst_linha", bus.linha_cache, 512'd0);
        verifica("rst_end", bus.endereco, 64'd0);
        verifica("rst_erro", erro, 1'b0);
        verifica("rst_zeros", cz, 16'h0000);

        // Basic burst with hand values
        for (int k = 0; k < 8; k++) begin
            nib = 4'(k + 1);
            envia_beat({16{nib}}, 64'h1234_5678_9ABC_DEF7, k == 7);
        end
        verifica("b1_end", bus.endereco, 64'h1234_5678_9ABC_DEC0);
        verifica("b1_lo", bus.linha_cache[63:0], 64'h1111_1111_1111_1111);
        verifica("b1_hi", bus.linha_cache[511:448], 64'h8888_8888_8888_8888);
        verifica("b1_nivel", nivel_fila, 3'd1);
        verifica("b1_valida", bus.linha_valida, 1'b1);
        bus.linha_pronta = 1'b1;
        @(negedge clk);
        bus.linha_pronta = 1'b0;
        verifica("b1_pop_nivel", nivel_fila, 3'd0);

        // Fill the FIFO and stall the fifth burst on its last beat
        for (int id = 1; id <= 4; id++) envia_rajada(id, 8, 7);
        verifica("cheia_nivel", nivel_fila, 3'd4);
        envia_rajada(5, 7, 99);
        bus.beat_valido = 1'b1; bus.beat_dado = dado(5, 7);
        bus.beat_endereco = end_de(5); bus.beat_ultimo = 1'b1;
        verifica("stall_pronto", bus.beat_pronto, 1'b0);
        repeat (3) @(negedge clk);
        verifica("stall_nivel", nivel_fila, 3'd4);
        verifica("stall_pronto2", bus.beat_pronto, 1'b0);
        verifica("stall_head", bus.linha_cache, linha_esp(1));
        bus.linha_pronta = 1'b1;
        @(negedge clk);
        bus.linha_pronta = 1'b0;
        verifica("stall_pos_pop_nivel", nivel_fila, 3'd3);
        verifica("stall_pos_pop_pronto", bus.beat_pronto, 1'b1);
        @(negedge clk);
        bus.beat_valido = 1'b0; bus.beat_ultimo = 1'b0;
        verifica("stall_fim_nivel", nivel_fila, 3'd4);
        for (int id = 2; id <= 5; id++) retira(id);
        verifica("dreno_nivel", nivel_fila, 3'd0);

        // Protocol errors
        envia_rajada(30, 3, 2);
        verifica("err3_pulso", erro, 1'b1);
        verifica("err3_nivel", nivel_fila, 3'd0);
        @(negedge clk);
        verifica("err3_fim", erro, 1'b0);
        envia_rajada(6, 8, 7);
        verifica("err3_seg_nivel", nivel_fila, 3'd1);
        retira(6);
        envia_rajada(31, 8, 99);
        verifica("err7_pulso", erro, 1'b1);
        verifica("err7_nivel", nivel_fila, 3'd0);
        envia_rajada(32, 1, 0);
        verifica("err1_pulso", erro, 1'b1);
        verifica("err1_nivel", nivel_fila, 3'd0);
        @(negedge clk);
        verifica("err1_fim", erro, 1'b0);

        // Simultaneous push and pop at level 2 across pointer wrap-around
        envia_rajada(10, 8, 7);
        envia_rajada(11, 8, 7);
        q_ids.push_back(10);
        q_ids.push_back(11);
        for (int id = 12; id <= 19; id++) begin
            envia_rajada(id, 7, 99);
            verifica("sim_head", bus.linha_cache, linha_esp(q_ids[0]));
            bus.beat_valido = 1'b1; bus.beat_dado = dado(id, 7);
            bus.beat_endereco = end_de(id); bus.beat_ultimo = 1'b1;
            bus.linha_pronta = 1'b1;
            @(negedge clk);
            bus.beat_valido = 1'b0; bus.beat_ultimo = 1'b0; bus.linha_pronta = 1'b0;
            void'(q_ids.pop_front());
            q_ids.push_back(id);
            verifica("sim_nivel", nivel_fila, 3'd2);
        end
        while (q_ids.size() > 0) retira(q_ids.pop_front());
        verifica("sim_vazia", nivel_fila, 3'd0);

        // Asynchronous reset mid-burst with two lines queued
        envia_rajada(20, 8, 7);
        envia_rajada(21, 8, 7);
        envia_rajada(22, 5, 99);
        #2;
        reset = 1'b0;
        #1;
        verifica("arst_valida", bus.linha_valida, 1'b0);
        verifica("arst_nivel", nivel_fila, 3'd0);
        verifica("arst_linha", bus.linha_cache, 512'd0);
        verifica("arst_end", bus.endereco, 64'd0);
        verifica("arst_erro", erro, 1'b0);
        verifica("arst_pronto", bus.beat_pronto, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        envia_rajada(23, 8, 7);
        verifica("arst_novo_nivel", nivel_fila, 3'd1);
        retira(23);

        // All-zero burst
        for (int k = 0; k < 8; k++) envia_beat(64'd0, 64'h40, k == 7);
`ifdef MONTADOR_FILTRO_ZERO_EN
        verifica("zero_nivel", nivel_fila, 3'd0);
        verifica("zero_cont", cz, 16'h0001);
        verifica("zero_erro", erro, 1'b0);
`else
        verifica("zero_nivel", nivel_fila, 3'd1);
        verifica("zero_linha", bus.linha_cache, 512'd0);
        verifica("zero_valida", bus.linha_valida, 1'b1);
        verifica("zero_cont", cz, 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
        $finish;
    end
endmodule

// File: doc/montador_linha.md
# montador_linha

Upstream feeder for the hash-classification core. Assembles 64-bit memory-bus beats into 512-bit cache lines tagged with their line-aligned address, and buffers completed lines in a small FIFO. The core consumes each line through a valid/ready handshake. Enforces the 8-beat burst protocol and discards malformed bursts.

## Interface
- TAM_BEAT, 64, beat data width
- TAM_LINHA, 512, line width; beats per line BEATS = TAM_LINHA/TAM_BEAT = 8
- TAM_ENDERECO, 64, address width
- PROF_FILA, 4, FIFO depth in lines; power of two, ≥2

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low; asserted when 0
- beat_valido  in  1  beat present
- beat_dado  in  TAM_BEAT  beat payload
- beat_endereco  in  TAM_ENDERECO  byte address; sampled only on the first beat of a burst
- beat_ultimo  in  1  marks the final beat of a burst
- beat_pronto  out  1  block accepts a beat this cycle
- linha_cache  out  TAM_LINHA  head-of-FIFO line
- endereco  out  TAM_ENDERECO  head-of-FIFO line address, low 6 bits zero
- linha_valida  out  1  FIFO not empty
- linha_pronta  in  1  consumer pops the head when high together with linha_valida
- nivel_fila  out  $clog2(PROF_FILA)+1  FIFO occupancy
- erro_protocolo  out  1  one-cycle pulse when a burst is discarded
- contador_zeros  out  16  count of dropped all-zero lines

## Operation
- Beat handshake: a beat is accepted when beat_valido & beat_pronto. beat_pronto = ~(indice==7 & FIFO full), where full is the registered occupancy.
- FSM states:
  - OCIOSO: indice = 0. An accepted beat latches {beat_endereco[63:6], 6'b0}, writes bits [63:0], and moves to MONTANDO with indice = 1.
  - MONTANDO: an accepted beat k writes bits [64k+63:64k] and increments indice.
- Burst completion: the beat accepted at indice 7 with beat_ultimo = 1 pushes {line, address} into the FIFO and returns to OCIOSO.
- Protocol errors discard the partial line, pulse erro_protocolo and return to OCIOSO with indice 0. The offending beat is consumed, not re-interpreted as a new first beat. Error cases:
  - beat_ultimo = 1 at indice < 7
  - beat_ultimo = 0 at indice 7
- A single-beat burst (beat_ultimo on the first beat) is an error.
- FIFO: circular, write and read pointers one bit wider than the index, so full/empty are distinguishable on wrap-around.
  - Pop occurs when linha_valida & linha_pronta.
  - Push and pop in the same cycle are legal at any non-full occupancy; nivel_fila is unchanged.
- Reset (any time, including mid-burst): FSM to OCIOSO, indice 0, FIFO emptied, pointers 0, contador_zeros 0, and all outputs 0 (linha_cache, endereco, linha_valida, nivel_fila, erro_protocolo). beat_pronto is 1 immediately after reset.

## Timing
- Final beat accepted at cycle N: linha_valida = 1 and the line is visible at cycle N+1.
- Pop at cycle N: the next head, or linha_valida = 0, at cycle N+1.
- erro_protocolo is high exactly in the cycle after the offending beat.
- Throughput: one beat per cycle; one line per 8 cycles sustained while the consumer pops.
- linha_cache and endereco are don't-care while linha_valida = 0, except after reset, when they are 0.

## Configuration
- MONTADOR_FILTRO_ZERO_EN defined:
  - A completed line whose 512 bits are all zero is not pushed.
  - contador_zeros increments, saturating at 16'hFFFF.
  - The FSM returns to OCIOSO normally; no error pulse.
- Not defined: zero lines are pushed like any other line, and contador_zeros is tied to 0.

## Test plan
- Reset, then one burst at address 0x1234_5678_9ABC_DEF7 with beats 0x11..11 … 0x88..88 -> at N+1, endereco = 0x1234_5678_9ABC_DEC0, linha_cache[63:0] = 0x1111_1111_1111_1111, linha_cache[511:448] = 0x8888_8888_8888_8888, nivel_fila = 1.
- linha_pronta = 0 while 5 bursts are sent with PROF_FILA = 4 -> nivel_fila = 4. The 5th burst stalls at indice 7 with beat_pronto = 0, then completes one cycle after a pop.
- beat_ultimo on the 3rd beat -> erro_protocolo pulses once, FIFO unchanged, and the next 8-beat burst assembles correctly.
- Simultaneous final-beat push and head pop at nivel_fila = 2 -> nivel_fila stays 2 and lines come out in order across pointer wrap-around (push 10 lines total).
- reset asserted at beat 5 with 2 lines queued -> all outputs 0 asynchronously; after release, a fresh burst yields nivel_fila = 1.
- All-zero burst: with MONTADOR_FILTRO_ZERO_EN, nivel_fila stays 0 and contador_zeros = 1; without it, nivel_fila = 1 and linha_cache = 0.
